// File: rtl/sisc_pkg.sv
// Shared SISC definitions: opcodes, addressing-mode constant, instruction
// register field positions and the fetch-stage state encoding.
package sisc_pkg;

  // Four-bit opcode space of the SISC instruction set
  typedef enum logic [3:0] {
    OP_NOOP = 4'd0,
    OP_LOD  = 4'd1,
    OP_STR  = 4'd2,
    OP_SWP  = 4'd3,
    OP_BRA  = 4'd4,
    OP_BRR  = 4'd5,
    OP_BNE  = 4'd6,
    OP_BNR  = 4'd7,
    OP_ALU  = 4'd8,
    OP_HLT  = 4'd15
  } opcode_e;

  // Immediate addressing mode value carried in the mm field
  localparam logic [3:0] AM_IMM = 4'd8;

  // Instruction register field positions
  localparam int OPC_HI = 31;
  localparam int OPC_LO = 28;
  localparam int MM_HI  = 27;
  localparam int MM_LO  = 24;
  localparam int IMM_HI = 15;
  localparam int IMM_LO = 0;
  localparam int IMM_W  = IMM_HI - IMM_LO + 1;

  // Word loaded into the IR when a fetch times out
  localparam logic [31:0] NOOP_WORD = 32'h0000_0000;

  // Fetch-stage control states
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/sisc_pc_next.sv
// Next-PC selection: increment, absolute branch to the zero-extended
// immediate, or relative branch by the sign-extended immediate. All
// arithmetic wraps modulo 2^AW.
module sisc_pc_next
  import sisc_pkg::*;
#(
  parameter int AW = 16
) (
  input  logic [AW-1:0]    pc,
  input  logic [IMM_W-1:0] imm,
  input  logic             pc_sel,
  input  logic             br_sel,
  output logic [AW-1:0]    pc_next
);

  logic signed [AW-1:0] imm_sx;
  logic        [AW-1:0] imm_zx;

  // Extend the immediate both ways, then pick the next PC
  always_comb begin
    imm_sx  = AW'($signed(imm));
    imm_zx  = AW'(imm);
    pc_next = pc + AW'(1);
    if (pc_sel) begin
      if (br_sel) begin
        pc_next = imm_zx;
      end else begin
        pc_next = pc + $unsigned(imm_sx);
      end
    end
  end

endmodule

// File: rtl/sisc_fetch.sv
// SISC instruction-fetch stage. Owns the program counter and the
// instruction register, runs the req/ack fetch handshake with a wait
// timeout, and exposes the decoded IR fields to the control FSM.
module sisc_fetch
  import sisc_pkg::*;
#(
  parameter int AW       = 16,
  parameter int DW       = 32,
  parameter int MAX_WAIT = 15
) (
  input  logic          clk,
  input  logic          rst_f,
  input  logic          pc_rst,
  input  logic          pc_write,
  input  logic          pc_sel,
  input  logic          br_sel,
  input  logic          ir_load,
  output logic          im_req,
  output logic [AW-1:0] im_addr,
  input  logic          im_ack,
  input  logic [DW-1:0] im_data,
  output logic [DW-1:0] ir,
  output logic [3:0]    opcode,
  output logic [3:0]    mm,
  output logic [15:0]   imm,
  output logic [AW-1:0] pc_out,
  output logic          fetch_busy,
  output logic          fetch_err
);

  // Counter must be able to hold MAX_WAIT itself
  localparam int CW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

  fetch_state_e         state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [CW-1:0]        cnt_inc;
  logic [AW-1:0]        addr_q, addr_d;
  logic [DW-1:0]        ir_q, ir_d;
  logic [AW-1:0]        pc_q, pc_d;
  logic                 err_q, err_d;
  logic [AW-1:0]        pc_nxt;

  // Next-PC datapath; the immediate operand is always the current IR
  sisc_pc_next #(
    .AW (AW)
  ) u_pc_next (
    .pc      (pc_q),
    .imm     (ir_q[IMM_HI:IMM_LO]),
    .pc_sel  (pc_sel),
    .br_sel  (br_sel),
    .pc_next (pc_nxt)
  );

  // Memory request: issued straight from ir_load in IDLE, held while BUSY.
  // Gated by both resets so an aborted fetch drops the request at once.
  always_comb begin
    im_req  = 1'b0;
    im_addr = pc_q;
    if (rst_f && !pc_rst) begin
      im_req = (state_q == ST_BUSY) || ir_load;
    end
    if (state_q == ST_BUSY) begin
      im_addr = addr_q;
    end
  end

  // Next-state logic for the fetch FSM, wait counter, IR, PC and error flag
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    ir_d    = ir_q;
    pc_d    = pc_q;
    err_d   = err_q;
    cnt_inc = cnt_q + CW'(1);

    if (pc_rst) begin
      // Clear PC and error, abandon any outstanding fetch, keep the IR
      state_d = ST_IDLE;
      cnt_d   = '0;
      pc_d    = '0;
      err_d   = 1'b0;
    end else begin
      if (pc_write) begin
        pc_d = pc_nxt;
      end

      case (state_q)
        ST_IDLE: begin
          if (ir_load) begin
            // Fetch address is the PC before any same-cycle update
            addr_d = pc_q;
            if (im_ack) begin
              ir_d = im_data;
            end else begin
              state_d = ST_BUSY;
              cnt_d   = '0;
            end
          end
        end
        ST_BUSY: begin
          if (im_ack) begin
            ir_d    = im_data;
            state_d = ST_IDLE;
          end else if (cnt_inc == CW'(MAX_WAIT)) begin
            // Memory never answered: substitute a NOOP and flag it
            ir_d    = DW'(NOOP_WORD);
            err_d   = 1'b1;
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State and datapath registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      ir_q    <= '0;
      pc_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      ir_q    <= ir_d;
      pc_q    <= pc_d;
      err_q   <= err_d;
    end
  end

  assign ir         = ir_q;
  assign opcode     = ir_q[OPC_HI:OPC_LO];
  assign mm         = ir_q[MM_HI:MM_LO];
  assign imm        = ir_q[IMM_HI:IMM_LO];
  assign pc_out     = pc_q;
  assign fetch_busy = (state_q == ST_BUSY);
  assign fetch_err  = err_q;

endmodule

// File: tb/tb_sisc_fetch.sv
// Bench for sisc_fetch: directed stimulus pushes expected IR and PC values
// into queues; a monitor pops and compares them whenever the DUT completes
// a fetch or a PC update. Control flags are checked inline.
module tb_sisc_fetch;

  localparam int AW = 16;
  localparam int DW = 32;

  logic          clk;
  logic          rst_f;
  logic          pc_rst;
  logic          pc_write;
  logic          pc_sel;
  logic          br_sel;
  logic          ir_load;
  logic          im_req;
  logic [AW-1:0] im_addr;
  logic          im_ack;
  logic [DW-1:0] im_data;
  logic [DW-1:0] ir;
  logic [3:0]    opcode;
  logic [3:0]    mm;
  logic [15:0]   imm;
  logic [AW-1:0] pc_out;
  logic          fetch_busy;
  logic          fetch_err;

  sisc_fetch #(
    .AW       (AW),
    .DW       (DW),
    .MAX_WAIT (15)
  ) dut (
    .clk        (clk),
    .rst_f      (rst_f),
    .pc_rst     (pc_rst),
    .pc_write   (pc_write),
    .pc_sel     (pc_sel),
    .br_sel     (br_sel),
    .ir_load    (ir_load),
    .im_req     (im_req),
    .im_addr    (im_addr),
    .im_ack     (im_ack),
    .im_data    (im_data),
    .ir         (ir),
    .opcode     (opcode),
    .mm         (mm),
    .imm        (imm),
    .pc_out     (pc_out),
    .fetch_busy (fetch_busy),
    .fetch_err  (fetch_err)
  );

  typedef struct {
    string       tag;
    logic [31:0] v;
  } exp_t;

  exp_t fq[$];
  exp_t pq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic exp_ir(input string t, input logic [31:0] v);
    exp_t e;
    e.tag = t;
    e.v   = v;
    fq.push_back(e);
  endtask

  task automatic exp_pc(input string t, input logic [31:0] v);
    exp_t e;
    e.tag = t;
    e.v   = v;
    pq.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_in();
    ir_load  = 1'b0;
    pc_write = 1'b0;
    pc_sel   = 1'b0;
    br_sel   = 1'b0;
    pc_rst   = 1'b0;
    im_ack   = 1'b0;
  endtask

  // Monitor: detect fetch completion / PC update at each edge and compare
  initial begin : monitor
    logic pre_req, pre_ack, pre_busy, pre_pcrst, pre_pcw;
    exp_t e;
    forever begin
      @(posedge clk);
      if (rst_f) begin
        pre_req   = im_req;
        pre_ack   = im_ack;
        pre_busy  = fetch_busy;
        pre_pcrst = pc_rst;
        pre_pcw   = pc_write;
        #1;
        if ((pre_req && pre_ack && !pre_pcrst) ||
            (pre_busy && !pre_ack && !pre_pcrst && !fetch_busy)) begin
          if (fq.size() == 0) begin
            chk("ir_unexpected_update", ir, 32'hxxxx_xxxx);
          end else begin
            e = fq.pop_front();
            chk(e.tag, ir, e.v);
          end
        end
        if (pre_pcw || pre_pcrst) begin
          if (pq.size() == 0) begin
            chk("pc_unexpected_update", 32'(pc_out), 32'hxxxx_xxxx);
          end else begin
            e = pq.pop_front();
            chk(e.tag, 32'(pc_out), e.v);
          end
        end
      end
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // Directed stimulus
  initial begin : stim
    rst_f   = 1'b0;
    idle_in();
    im_data = '0;
    ir_load = 1'b1;
    #3;
    chk("rst_im_req", 32'(im_req), 32'd0);
    chk("rst_im_addr", 32'(im_addr), 32'd0);
    chk("rst_busy", 32'(fetch_busy), 32'd0);
    chk("rst_err", 32'(fetch_err), 32'd0);
    chk("rst_ir", ir, 32'd0);
    chk("rst_fields", {opcode, mm, imm}, 32'd0);
    chk("rst_pc", 32'(pc_out), 32'd0);
    ir_load = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_f = 1'b1;

    // Zero-wait fetch with increment
    ir_load = 1'b1; pc_write = 1'b1; im_ack = 1'b1; im_data = 32'h1800_0005;
    #1;
    chk("zw_im_req", 32'(im_req), 32'd1);
    chk("zw_im_addr", 32'(im_addr), 32'h0000);
    exp_ir("zw_ir", 32'h1800_0005);
    exp_pc("zw_pc", 32'h0001);
    tick(); idle_in();
    chk("zw_opcode", 32'(opcode), 32'd1);
    chk("zw_mm", 32'(mm), 32'd8);
    chk("zw_imm", 32'(imm), 32'd5);
    chk("zw_busy", 32'(fetch_busy), 32'd0);

    // Advance PC to 4
    pc_write = 1'b1;
    exp_pc("inc_pc2", 32'h0002);
    exp_pc("inc_pc3", 32'h0003);
    exp_pc("inc_pc4", 32'h0004);
    repeat (3) tick();
    idle_in();

    // Three-cycle memory, ir_load held high throughout
    ir_load = 1'b1; im_data = 32'h4000_0010;
    #1;
    chk("w3_req0", 32'(im_req), 32'd1);
    chk("w3_addr0", 32'(im_addr), 32'h0004);
    tick();
    pc_write = 1'b1;
    exp_pc("w3_pc5", 32'h0005);
    #1;
    chk("w3_busy1", 32'(fetch_busy), 32'd1);
    chk("w3_req1", 32'(im_req), 32'd1);
    chk("w3_addr1", 32'(im_addr), 32'h0004);
    chk("w3_ir_hold1", ir, 32'h1800_0005);
    tick();
    pc_write = 1'b0; im_ack = 1'b1;
    #1;
    chk("w3_busy2", 32'(fetch_busy), 32'd1);
    chk("w3_addr2", 32'(im_addr), 32'h0004);
    chk("w3_ir_hold2", ir, 32'h1800_0005);
    exp_ir("w3_ir", 32'h4000_0010);
    tick(); idle_in();
    #1;
    chk("w3_busy_end", 32'(fetch_busy), 32'd0);
    chk("w3_req_end", 32'(im_req), 32'd0);

    // Absolute branch to 0x0010
    pc_write = 1'b1; pc_sel = 1'b1; br_sel = 1'b1;
    exp_pc("abs_0010", 32'h0010);
    tick(); idle_in();

    // Fetch BRA 0x0040 at 0x0010
    ir_load = 1'b1; im_ack = 1'b1; im_data = 32'h4000_0040;
    #1;
    chk("f_addr_0010", 32'(im_addr), 32'h0010);
    exp_ir("f_ir_bra40", 32'h4000_0040);
    tick(); idle_in();

    // Absolute branch with simultaneous fetch: old PC fetched, old IR used
    pc_write = 1'b1; pc_sel = 1'b1; br_sel = 1'b1;
    ir_load = 1'b1; im_ack = 1'b1; im_data = 32'h5000_FFFE;
    #1;
    chk("sim_addr", 32'(im_addr), 32'h0010);
    exp_pc("abs_0040", 32'h0040);
    exp_ir("sim_ir", 32'h5000_FFFE);
    tick(); idle_in();
    chk("sim_opcode", 32'(opcode), 32'd5);
    chk("sim_imm", 32'(imm), 32'h0000_FFFE);

    // Relative branch -2 from 0x0040, fetching BRA 0x0010
    pc_write = 1'b1; pc_sel = 1'b1; br_sel = 1'b0;
    ir_load = 1'b1; im_ack = 1'b1; im_data = 32'h4000_0010;
    #1;
    chk("rel1_addr", 32'(im_addr), 32'h0040);
    exp_pc("rel_003e", 32'h003E);
    exp_ir("rel1_ir", 32'h4000_0010);
    tick(); idle_in();

    // Absolute back to 0x0010, fetching the -2 relative branch
    pc_write = 1'b1; pc_sel = 1'b1; br_sel = 1'b1;
    ir_load = 1'b1; im_ack = 1'b1; im_data = 32'h5000_FFFE;
    #1;
    chk("abs2_addr", 32'(im_addr), 32'h003E);
    exp_pc("abs_0010b", 32'h0010);
    exp_ir("abs2_ir", 32'h5000_FFFE);
    tick(); idle_in();

    // Relative 0xFFFE from 0x0010
    pc_write = 1'b1; pc_sel = 1'b1; br_sel = 1'b0;
    exp_pc("rel_000e", 32'h000E);
    tick(); idle_in();

    // Wrap: branch to 0xFFFF then increment
    ir_load = 1'b1; im_ack = 1'b1; im_data = 32'h4000_FFFF;
    #1;
    chk("wrap_fetch_addr", 32'(im_addr), 32'h000E);
    exp_ir("wrap_ir", 32'h4000_FFFF);
    tick(); idle_in();
    pc_write = 1'b1; pc_sel = 1'b1; br_sel = 1'b1;
    exp_pc("abs_ffff", 32'hFFFF);
    tick(); idle_in();
    pc_write = 1'b1;
    exp_pc("wrap_0000", 32'h0000);
    tick(); idle_in();

    // Timeout after 15 BUSY cycles
    ir_load = 1'b1;
    #1;
    chk("to_addr", 32'(im_addr), 32'h0000);
    tick();
    ir_load = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      chk($sformatf("to_busy_c%0d", k), 32'(fetch_busy), 32'd1);
      chk($sformatf("to_err_c%0d", k), 32'(fetch_err), 32'd0);
      tick();
    end
    chk("to_busy_c15", 32'(fetch_busy), 32'd1);
    exp_ir("to_noop", 32'h0000_0000);
    tick();
    chk("to_busy_after", 32'(fetch_busy), 32'd0);
    chk("to_err_set", 32'(fetch_err), 32'd1);
    chk("to_req_after", 32'(im_req), 32'd0);

    // Sticky error across a good fetch and PC updates
    ir_load = 1'b1; im_ack = 1'b1; im_data = 32'h8000_1234;
    exp_ir("sticky_ir", 32'h8000_1234);
    tick(); idle_in();
    chk("err_sticky1", 32'(fetch_err), 32'd1);
    pc_write = 1'b1;
    exp_pc("st_pc1", 32'h0001);
    exp_pc("st_pc2", 32'h0002);
    repeat (2) tick();
    idle_in();
    chk("err_sticky2", 32'(fetch_err), 32'd1);
    pc_rst = 1'b1; pc_write = 1'b1;
    exp_pc("pcrst_pc0", 32'h0000);
    tick(); idle_in();
    chk("pcrst_err_clr", 32'(fetch_err), 32'd0);

    // pc_rst while BUSY with pc_write also high
    pc_write = 1'b1;
    exp_pc("ab_pc1", 32'h0001);
    tick(); idle_in();
    ir_load = 1'b1; pc_write = 1'b1;
    exp_pc("ab_pc2", 32'h0002);
    #1;
    chk("ab_addr", 32'(im_addr), 32'h0001);
    tick(); idle_in();
    chk("ab_busy", 32'(fetch_busy), 32'd1);
    pc_rst = 1'b1; pc_write = 1'b1;
    exp_pc("ab_pc0", 32'h0000);
    tick(); idle_in();
    #1;
    chk("ab_busy_clr", 32'(fetch_busy), 32'd0);
    chk("ab_req_clr", 32'(im_req), 32'd0);
    chk("ab_ir_keep", ir, 32'h8000_1234);
    im_ack = 1'b1; im_data = 32'hDEAD_BEEF;
    tick(); idle_in();
    chk("stray_ack_ir", ir, 32'h8000_1234);

    // Asynchronous reset in the middle of a fetch
    pc_write = 1'b1;
    exp_pc("ar_pc1", 32'h0001);
    tick(); idle_in();
    ir_load = 1'b1;
    tick();
    ir_load = 1'b0;
    #1;
    chk("ar_busy", 32'(fetch_busy), 32'd1);
    chk("ar_req", 32'(im_req), 32'd1);
    #3;
    rst_f = 1'b0;
    #1;
    chk("ar_req0", 32'(im_req), 32'd0);
    chk("ar_addr0", 32'(im_addr), 32'd0);
    chk("ar_busy0", 32'(fetch_busy), 32'd0);
    chk("ar_err0", 32'(fetch_err), 32'd0);
    chk("ar_ir0", ir, 32'd0);
    chk("ar_fields0", {opcode, mm, imm}, 32'd0);
    chk("ar_pc0", 32'(pc_out), 32'd0);
    im_ack = 1'b1; im_data = 32'hFFFF_FFFF;
    @(posedge clk);
    #2;
    rst_f = 1'b1;
    tick();
    chk("ar_late_ack_ir", ir, 32'd0);
    chk("ar_late_busy", 32'(fetch_busy), 32'd0);
    idle_in();
    repeat (2) tick();

    chk("fetch_queue_drained", 32'(fq.size()), 32'd0);
    chk("pc_queue_drained", 32'(pq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
